// File: rtl/lif_membrane_pkg.sv
// Shared definitions for the LIF membrane stage: default widths common with the
// upstream adder tree and the two-state FSM encoding.
package lif_membrane_pkg;

    // Default widths shared with the weighted-input adder tree.
    localparam int LIF_N_STAGE   = 5;
    localparam int LIF_U_W       = 8;
    localparam int LIF_SHIFT_W   = 3;
    localparam int LIF_REFRACT_W = 4;

    // FSM encoding, kept as plain constants for compatibility with older flows.
    typedef logic [0:0] lif_state_t;
    localparam lif_state_t LIF_ST_INTEGRATE  = 1'b0;
    localparam lif_state_t LIF_ST_REFRACTORY = 1'b1;

endpackage

// File: rtl/lif_membrane_if.sv
// Bus between the adder tree / configuration side (master) and the membrane
// stage (slave): tree sum with its valid, live neuron parameters, and the
// registered spike / membrane / refractory outputs.
interface lif_membrane_if #(
    parameter int N_STAGE   = 5,
    parameter int U_W       = 8,
    parameter int SHIFT_W   = 3,
    parameter int REFRACT_W = 4
);
    logic [N_STAGE+1:0]   sum_in;
    logic                 sum_valid;
    logic [U_W-1:0]       threshold;
    logic [SHIFT_W-1:0]   leak_shift;
    logic [REFRACT_W-1:0] refract_cycles;
    logic                 spike;
    logic [U_W-1:0]       membrane;
    logic                 refractory;

    modport master (
        output sum_in, sum_valid, threshold, leak_shift, refract_cycles,
        input  spike, membrane, refractory
    );

    modport slave (
        input  sum_in, sum_valid, threshold, leak_shift, refract_cycles,
        output spike, membrane, refractory
    );
endinterface

// File: rtl/lif_refractory_counter.sv
// Refractory down-counter. Load takes priority over decrement; done flags the
// terminal count of 1 so the owner can leave the refractory state on that edge.
module lif_refractory_counter #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    input  logic         i_dec,
    output logic         o_done
);
    logic [W-1:0] r_count;

    // Load on fire, otherwise count down toward zero while decrementing.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_dec && (r_count != '0)) begin
            r_count <= r_count - W'(1);
        end
    end

    assign o_done = (r_count == W'(1));

endmodule

// File: rtl/lif_membrane.sv
// Leaky integrate-and-fire membrane stage.
// Optional build macro: LIF_SUBTRACT_RESET_EN keeps the residual (t - threshold)
// on fire instead of clearing the membrane.
//
//   state       | meaning
//   ------------+-----------------------------------------------------------
//   INTEGRATE   | leak + add + saturate + compare on every valid sample
//   REFRACTORY  | inputs ignored, membrane held, counter runs to terminal
module lif_membrane
    import lif_membrane_pkg::*;
#(
    parameter int N_STAGE   = LIF_N_STAGE,
    parameter int U_W       = LIF_U_W,
    parameter int SHIFT_W   = LIF_SHIFT_W,
    parameter int REFRACT_W = LIF_REFRACT_W
) (
    input  logic          clk,
    input  logic          reset,
    lif_membrane_if.slave bus
);
    localparam int SUM_W = N_STAGE + 2;

    logic [U_W-1:0] r_u;
    logic           r_spike;
    lif_state_t     r_state;

    logic [U_W-1:0] w_leak;
    logic [U_W:0]   w_t_wide;
    logic [U_W-1:0] w_t;
    logic [U_W-1:0] w_u_fire;
    logic           w_integrate;
    logic           w_fire;
    logic           w_load;
    logic           w_dec;
    logic           w_done;

    // Leak, add and saturate. The extra MSB catches overflow; u - leak never
    // underflows because leak is u shifted right.
    always_comb begin
        w_leak   = (bus.leak_shift != '0) ? (r_u >> bus.leak_shift) : '0;
        w_t_wide = {1'b0, r_u} - {1'b0, w_leak}
                 + {{(U_W + 1 - SUM_W){1'b0}}, bus.sum_in};
        w_t      = w_t_wide[U_W] ? {U_W{1'b1}} : w_t_wide[U_W-1:0];
    end

    // Fire decision and the membrane value left behind after a spike.
    always_comb begin
        w_integrate = (r_state == LIF_ST_INTEGRATE) && bus.sum_valid;
        w_fire      = w_integrate && (w_t >= bus.threshold);
        w_load      = w_fire && (bus.refract_cycles != '0);
        w_dec       = (r_state == LIF_ST_REFRACTORY);
`ifdef LIF_SUBTRACT_RESET_EN
        w_u_fire    = w_t - bus.threshold;
`else
        w_u_fire    = '0;
`endif
    end

    lif_refractory_counter #(
        .W (REFRACT_W)
    ) u_refract_cnt (
        .clk        (clk),
        .reset      (reset),
        .i_load     (w_load),
        .i_load_val (bus.refract_cycles),
        .i_dec      (w_dec),
        .o_done     (w_done)
    );

    // FSM: enter refractory only when a fire carries a non-zero period, leave
    // on the counter's terminal count.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= LIF_ST_INTEGRATE;
        end else begin
            case (r_state)
                LIF_ST_INTEGRATE:  if (w_load) r_state <= LIF_ST_REFRACTORY;
                LIF_ST_REFRACTORY: if (w_done) r_state <= LIF_ST_INTEGRATE;
                default:           r_state <= LIF_ST_INTEGRATE;
            endcase
        end
    end

    // Membrane and spike registers; membrane only moves on accepted samples.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_u     <= '0;
            r_spike <= 1'b0;
        end else begin
            r_spike <= w_fire;
            if (w_fire) begin
                r_u <= w_u_fire;
            end else if (w_integrate) begin
                r_u <= w_t;
            end
        end
    end

    assign bus.spike      = r_spike;
    assign bus.membrane   = r_u;
    assign bus.refractory = (r_state == LIF_ST_REFRACTORY);

endmodule
